// File: rtl/equ_cmp_bank.sv
// equ_cmp_bank
// Bank of independent equality comparators against a shared counter,
// typically used to raise line-count events from a video timing counter.
//
// Ports:
//   MasterClock  sole clock, all state changes on the rising edge
//   nRESET       asynchronous active-low reset, clears all state
//   CNT          counter value compared against every channel
//   WR           strobe: CMP[WSEL] <= WDATA
//   CWR          strobe: {ONESHOT,EN}[WSEL] <= WDATA[1:0]
//   WSEL         channel select for WR/CWR (values >= CHANNELS are ignored)
//   WDATA        write data
//   ACK          per-channel pending-clear strobes
//   HIT          one-cycle pulse on the rising edge of a channel's match
//   PEND         sticky per-channel pending flag
//   IRQ          registered OR of PEND
module equ_cmp_bank #(
  parameter int WIDTH    = 9,
  parameter int CHANNELS = 4,
  parameter int SELW     = 3
) (
  input  logic                MasterClock,
  input  logic                nRESET,
  input  logic [WIDTH-1:0]    CNT,
  input  logic                WR,
  input  logic                CWR,
  input  logic [SELW-1:0]     WSEL,
  input  logic [WIDTH-1:0]    WDATA,
  input  logic [CHANNELS-1:0] ACK,
  output logic [CHANNELS-1:0] HIT,
  output logic [CHANNELS-1:0] PEND,
  output logic                IRQ
);

  logic [CHANNELS-1:0] match_p0;
  logic [CHANNELS-1:0] rise_p0;
  logic [CHANNELS-1:0] md_p1;

  // ---- stage 0: per-channel configuration and raw match ----
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    logic [WIDTH-1:0] cmp;
    logic             en;
    logic             oneshot;
    logic             sel;

    // An out-of-range WSEL never equals any channel index, so such
    // writes fall through without touching state.
    assign sel         = (WSEL == SELW'(c));
    assign match_p0[c] = en & (CNT == cmp);
    assign rise_p0[c]  = match_p0[c] & ~md_p1[c];

    always_ff @(posedge MasterClock or negedge nRESET) begin
      if (!nRESET) begin
        cmp     <= '0;
        en      <= 1'b0;
        oneshot <= 1'b0;
      end else begin
        if (WR && sel) begin
          cmp <= WDATA;
        end
        // A host control write takes priority over the one-shot disarm
        // happening on the same edge.
        if (CWR && sel) begin
          en      <= WDATA[0];
          oneshot <= WDATA[1];
        end else if (oneshot && rise_p0[c]) begin
          en <= 1'b0;
        end
      end
    end
  end

  // ---- stage 1: match history, hit pulse, pending flags ----
  always_ff @(posedge MasterClock or negedge nRESET) begin
    if (!nRESET) begin
      md_p1 <= '0;
      HIT   <= '0;
      PEND  <= '0;
    end else begin
      md_p1 <= match_p0;
      HIT   <= rise_p0;
      // A new hit wins over an acknowledge on the same edge.
      PEND  <= rise_p0 | (PEND & ~ACK);
    end
  end

  // ---- stage 2: interrupt request ----
  always_ff @(posedge MasterClock or negedge nRESET) begin
    if (!nRESET) begin
      IRQ <= 1'b0;
    end else begin
      IRQ <= |PEND;
    end
  end

endmodule

// File: tb/tb_equ_cmp_bank.sv
// Testbench for equ_cmp_bank (WIDTH=9, CHANNELS=4, SELW=3).
module tb_equ_cmp_bank;

  localparam int W  = 9;
  localparam int CH = 4;
  localparam int SW = 3;

  logic          clk;
  logic          rst_n;
  logic [W-1:0]  cnt;
  logic          wr;
  logic          cwr;
  logic [SW-1:0] wsel;
  logic [W-1:0]  wdata;
  logic [CH-1:0] ack;
  logic [CH-1:0] hit;
  logic [CH-1:0] pend;
  logic          irq;

  equ_cmp_bank #(.WIDTH(W), .CHANNELS(CH), .SELW(SW)) dut (
    .MasterClock(clk),
    .nRESET(rst_n),
    .CNT(cnt),
    .WR(wr),
    .CWR(cwr),
    .WSEL(wsel),
    .WDATA(wdata),
    .ACK(ack),
    .HIT(hit),
    .PEND(pend),
    .IRQ(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, straight from the channel rules.
  int       m_cmp[CH];
  bit       m_en[CH];
  bit       m_os[CH];
  bit       m_prev[CH];
  bit       m_hit[CH];
  bit       m_pend[CH];
  bit       m_irq;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_cmp[c] = 0; m_en[c] = 0; m_os[c] = 0;
      m_prev[c] = 0; m_hit[c] = 0; m_pend[c] = 0;
    end
    m_irq = 0;
  endtask

  // One clock edge of the model, using the inputs present before the edge.
  task automatic model_edge();
    bit any_pend;
    bit matched;
    int sel;
    any_pend = 0;
    for (int c = 0; c < CH; c++) any_pend |= m_pend[c];
    m_irq = any_pend;
    for (int c = 0; c < CH; c++) begin
      matched = m_en[c] && (int'(cnt) == m_cmp[c]);
      m_hit[c] = matched && !m_prev[c];
      if (m_hit[c]) m_pend[c] = 1;
      else if (ack[c]) m_pend[c] = 0;
      if (m_hit[c] && m_os[c]) m_en[c] = 0;
      m_prev[c] = matched;
    end
    sel = int'(wsel);
    if (sel < CH) begin
      if (wr) m_cmp[sel] = int'(wdata);
      if (cwr) begin
        m_en[sel] = wdata[0];
        m_os[sel] = wdata[1];
      end
    end
  endtask

  function automatic logic [CH-1:0] pack(input bit v[CH]);
    logic [CH-1:0] r;
    for (int c = 0; c < CH; c++) r[c] = v[c];
    return r;
  endfunction

  task automatic clr();
    wr = 0; cwr = 0; ack = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic step();
    tick();
    chk("model_hit", 32'(hit), 32'(pack(m_hit)));
    chk("model_pend", 32'(pend), 32'(pack(m_pend)));
    chk("model_irq", 32'(irq), 32'(m_irq));
    clr();
  endtask

  typedef struct {
    logic [W-1:0]  cnt;
    bit            wr;
    bit            cwr;
    logic [SW-1:0] wsel;
    logic [W-1:0]  wdata;
    logic [CH-1:0] ack;
    logic [CH-1:0] hit;
    logic [CH-1:0] pend;
    bit            irq;
  } vec_t;

  vec_t tbl[20];
  int   n;

  initial begin
    // cnt, wr, cwr, wsel, wdata, ack, exp hit, exp pend, exp irq
    tbl[0]  = '{9'd0,   1, 0, 3'd0, 9'd100, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[1]  = '{9'd98,  0, 1, 3'd0, 9'd1,   4'b0000, 4'b0000, 4'b0000, 0};
    tbl[2]  = '{9'd99,  0, 0, 3'd0, 9'd0,   4'b0000, 4'b0000, 4'b0000, 0};
    tbl[3]  = '{9'd100, 0, 0, 3'd0, 9'd0,   4'b0000, 4'b0001, 4'b0001, 0};
    tbl[4]  = '{9'd101, 0, 0, 3'd0, 9'd0,   4'b0000, 4'b0000, 4'b0001, 1};
    tbl[5]  = '{9'd102, 0, 0, 3'd0, 9'd0,   4'b0000, 4'b0000, 4'b0001, 1};
    tbl[6]  = '{9'd102, 0, 0, 3'd0, 9'd0,   4'b0001, 4'b0000, 4'b0000, 1};
    tbl[7]  = '{9'd102, 0, 0, 3'd0, 9'd0,   4'b0000, 4'b0000, 4'b0000, 0};
    tbl[8]  = '{9'd510, 1, 0, 3'd0, 9'd511, 4'b0000, 4'b0000, 4'b0000, 0};
    tbl[9]  = '{9'd511, 0, 0, 3'd0, 9'd0,   4'b0000, 4'b0001, 4'b0001, 0};
    tbl[10] = '{9'd0,   1, 0, 3'd7, 9'd2,   4'b0000, 4'b0000, 4'b0001, 1};
    tbl[11] = '{9'd1,   1, 0, 3'd0, 9'd0,   4'b0001, 4'b0000, 4'b0000, 1};
    tbl[12] = '{9'd511, 0, 0, 3'd0, 9'd0,   4'b0000, 4'b0000, 4'b0000, 0};
    tbl[13] = '{9'd0,   0, 0, 3'd0, 9'd0,   4'b0000, 4'b0001, 4'b0001, 0};
    tbl[14] = '{9'd1,   0, 0, 3'd0, 9'd0,   4'b0001, 4'b0000, 4'b0000, 1};
    tbl[15] = '{9'd2,   0, 0, 3'd0, 9'd0,   4'b0000, 4'b0000, 4'b0000, 0};
    tbl[16] = '{9'd5,   0, 1, 3'd7, 9'd0,   4'b0000, 4'b0000, 4'b0000, 0};
    tbl[17] = '{9'd0,   0, 0, 3'd0, 9'd0,   4'b0000, 4'b0001, 4'b0001, 0};
    tbl[18] = '{9'd3,   0, 0, 3'd0, 9'd0,   4'b0001, 4'b0000, 4'b0000, 1};
    tbl[19] = '{9'd3,   0, 0, 3'd0, 9'd0,   4'b0000, 4'b0000, 4'b0000, 0};

    rst_n = 0; cnt = '0; wsel = '0; wdata = '0; clr();
    model_reset();
    #1;
    chk("reset_hit", 32'(hit), 32'd0);
    chk("reset_pend", 32'(pend), 32'd0);
    chk("reset_irq", 32'(irq), 32'd0);
    #20 rst_n = 1;
    @(negedge clk);

    // Table-driven directed vectors: basic hit, ack, wrap, ignored WSEL.
    for (int i = 0; i < 20; i++) begin
      cnt = tbl[i].cnt; wr = tbl[i].wr; cwr = tbl[i].cwr;
      wsel = tbl[i].wsel; wdata = tbl[i].wdata; ack = tbl[i].ack;
      tick();
      chk($sformatf("tbl%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
      chk($sformatf("tbl%0d_pend", i), 32'(pend), 32'(tbl[i].pend));
      chk($sformatf("tbl%0d_irq", i), 32'(irq), 32'(tbl[i].irq));
      clr();
    end

    // Held match gives a single hit; dropping match re-arms.
    cnt = 9'd300; wr = 1; wsel = 3'd1; wdata = 9'd100; step();
    cwr = 1; wsel = 3'd1; wdata = 9'd1; step();
    n = 0;
    cnt = 9'd100;
    for (int i = 0; i < 10; i++) begin
      step();
      if (hit[1]) n++;
    end
    chk("hold_single_hit", 32'(n), 32'd1);
    cnt = 9'd101; step();
    cnt = 9'd100; step();
    chk("rearm_hit1", 32'(hit[1]), 32'd1);

    // One-shot channel fires once and disarms; pend waits for ack.
    cnt = 9'd300; wr = 1; wsel = 3'd2; wdata = 9'd5; step();
    cwr = 1; wsel = 3'd2; wdata = 9'd3; step();
    n = 0;
    for (int r = 0; r < 2; r++) begin
      for (int v = 0; v < 8; v++) begin
        cnt = W'(v); step();
        if (hit[2]) n++;
      end
    end
    chk("oneshot_hits", 32'(n), 32'd1);
    chk("oneshot_pend", 32'(pend[2]), 32'd1);
    cnt = 9'd300; ack = 4'b0100; step();
    chk("oneshot_ack", 32'(pend[2]), 32'd0);

    // Ack colliding with a new hit: set wins.
    ack = 4'hf; step();
    wr = 1; wsel = 3'd3; wdata = 9'd50; step();
    cwr = 1; wsel = 3'd3; wdata = 9'd1; step();
    cnt = 9'd49; step();
    cnt = 9'd50; ack = 4'b1000; step();
    chk("collide_hit3", 32'(hit[3]), 32'd1);
    chk("collide_pend3", 32'(pend[3]), 32'd1);
    cnt = 9'd51; ack = 4'b1000; step();
    chk("ack_pend_all", 32'(pend), 32'd0);
    step();
    chk("ack_irq", 32'(irq), 32'd0);

    // Asynchronous reset in the middle of a held match.
    wr = 1; wsel = 3'd0; wdata = 9'd20; step();
    cnt = 9'd20; step(); step(); step();
    chk("pre_reset_pend", 32'(pend[0]), 32'd1);
    #3 rst_n = 0;
    #1;
    chk("async_hit", 32'(hit), 32'd0);
    chk("async_pend", 32'(pend), 32'd0);
    chk("async_irq", 32'(irq), 32'd0);
    model_reset();
    #2 rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_reset_nohit", 32'(hit), 32'd0);
    end
    // Match present on the first edge after enabling must hit.
    cnt = 9'd0; cwr = 1; wsel = 3'd0; wdata = 9'd1; step();
    step();
    chk("first_match_hit", 32'(hit[0]), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 1) == 1) cnt = W'($urandom_range(0, 15));
      wr    = ($urandom_range(0, 7) == 0);
      cwr   = ($urandom_range(0, 7) == 0);
      wsel  = SW'($urandom_range(0, 7));
      wdata = W'($urandom_range(0, 15));
      ack   = ($urandom_range(0, 3) == 0) ? CH'($urandom_range(0, 15)) : '0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
